// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL mode sequencer: reconfiguration register map,
// mode-table word layout and sequencer state encoding.
package pll_cfg_pkg;

  localparam logic [5:0] REG_MODE  = 6'd0;
  localparam logic [5:0] REG_START = 6'd2;
  localparam logic [5:0] REG_N     = 6'd3;
  localparam logic [5:0] REG_M     = 6'd4;
  localparam logic [5:0] REG_C     = 6'd5;
  localparam logic [5:0] REG_K     = 6'd7;

  localparam logic [5:0] TBL_TERM  = 6'h3F;

  typedef struct packed {
    logic [5:0]  reg_addr;
    logic [31:0] reg_data;
  } tbl_word_t;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_WR_MODE,
    S_FETCH,
    S_WR_ENT,
    S_START,
    S_WAIT_LOCK,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/pll_sync_stable.sv
// Two-flop synchroniser followed by a qualifier that reports when the
// synchronised value has held steady for STABLE consecutive cycles.
module pll_sync_stable #(
  parameter  int W      = 1,
  parameter  int STABLE = 1,
  localparam int CNT_W  = $clog2(STABLE + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         stable_o
);

  logic [W-1:0]     s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is the number of cycles, including the current one, that s2_q has held
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_W'(STABLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= CNT_W'(1);
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end

  assign q_o      = s2_q;
  assign stable_o = (cnt_q >= CNT_W'(STABLE));

endmodule

// File: rtl/pll_mode_sequencer.sv
// Sequences per-mode register writes from an external table ROM into a PLL
// reconfiguration controller, starts reconfiguration and waits for lock.
module pll_mode_sequencer
  import pll_cfg_pkg::*;
#(
  parameter  int NUM_MODES    = 2,
  parameter  int ENTRIES      = 8,
  parameter  int LOCK_TIMEOUT = 500000,
  parameter  int MODE_W       = $clog2(NUM_MODES),
  localparam int IDX_W        = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int TMR_W        = ($clog2(LOCK_TIMEOUT) > 5) ? $clog2(LOCK_TIMEOUT) : 5
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [MODE_W-1:0]       mode_sel,
  input  logic                    pll_locked,
  output logic [MODE_W+IDX_W-1:0] tbl_addr,
  input  logic [37:0]             tbl_data,
  output logic [5:0]              mgmt_address,
  output logic                    mgmt_write,
  output logic [31:0]             mgmt_writedata,
  input  logic                    mgmt_waitrequest,
  output logic                    busy,
  output logic [MODE_W-1:0]       cur_mode,
  output logic                    lock_err
);

  logic [MODE_W-1:0] mode_sync;
  logic              mode_stable, lock_sync, lock_stable, locked;

  pll_sync_stable #(.W(MODE_W), .STABLE(4)) u_mode_sync (
    .clk_i(refclk), .rst_i(rst), .d_i(mode_sel), .q_o(mode_sync), .stable_o(mode_stable)
  );

  pll_sync_stable #(.W(1), .STABLE(1)) u_lock_sync (
    .clk_i(refclk), .rst_i(rst), .d_i(pll_locked), .q_o(lock_sync), .stable_o(lock_stable)
  );

  assign locked = lock_sync & lock_stable;

  seq_state_t              state_q;
  logic [MODE_W-1:0]       tgt_q, seen_q, pend_q, cmp_mode;
  logic                    pend_vld_q, req_evt;
  logic [IDX_W-1:0]        idx_q;
  logic [TMR_W-1:0]        timer_q;
  logic [MODE_W+IDX_W-1:0] tbl_addr_q;
  logic [5:0]              mgmt_address_q;
  logic                    mgmt_write_q, busy_q, lock_err_q;
  logic [31:0]             mgmt_writedata_q;
  logic [MODE_W-1:0]       cur_mode_q;
  tbl_word_t               tbl_word;

  assign tbl_word = tbl_data;

  // A request event fires once per new stable value, so a timed-out target
  // is not retried until mode_sel actually moves again.
  assign req_evt = mode_stable && (mode_sync != seen_q);

  always_comb begin
    cmp_mode = tgt_q;
    if (state_q == S_IDLE) cmp_mode = pend_q;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q          <= S_BOOT;
      tgt_q            <= '0;
      seen_q           <= '0;
      pend_q           <= '0;
      pend_vld_q       <= 1'b0;
      idx_q            <= '0;
      timer_q          <= '0;
      tbl_addr_q       <= '0;
      mgmt_address_q   <= '0;
      mgmt_write_q     <= 1'b0;
      mgmt_writedata_q <= '0;
      busy_q           <= 1'b1;
      cur_mode_q       <= '0;
      lock_err_q       <= 1'b0;
    end else begin
      if (req_evt) seen_q <= mode_sync;

      case (state_q)
        S_BOOT: begin
          if (locked) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (pend_vld_q) begin
            pend_vld_q <= 1'b0;
            if (pend_q != cur_mode_q) begin
              tgt_q   <= pend_q;
              busy_q  <= 1'b1;
              state_q <= S_WR_MODE;
            end
          end else if (req_evt && (mode_sync != cur_mode_q)) begin
            tgt_q   <= mode_sync;
            busy_q  <= 1'b1;
            state_q <= S_WR_MODE;
          end
        end
        S_WR_MODE: begin
          if (!mgmt_write_q) begin
            mgmt_write_q     <= 1'b1;
            mgmt_address_q   <= REG_MODE;
            mgmt_writedata_q <= 32'd0;
          end else if (!mgmt_waitrequest) begin
            mgmt_write_q <= 1'b0;
            idx_q        <= '0;
            tbl_addr_q   <= {tgt_q, IDX_W'(0)};
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_WR_ENT;
        S_WR_ENT: begin
          if (!mgmt_write_q) begin
            if (tbl_word.reg_addr == TBL_TERM) begin
              state_q <= S_START;
            end else begin
              mgmt_write_q     <= 1'b1;
              mgmt_address_q   <= tbl_word.reg_addr;
              mgmt_writedata_q <= tbl_word.reg_data;
            end
          end else if (!mgmt_waitrequest) begin
            mgmt_write_q <= 1'b0;
            if (idx_q == IDX_W'(ENTRIES - 1)) begin
              state_q <= S_START;
            end else begin
              idx_q      <= idx_q + 1'b1;
              tbl_addr_q <= {tgt_q, idx_q + 1'b1};
              state_q    <= S_FETCH;
            end
          end
        end
        S_START: begin
          if (!mgmt_write_q) begin
            mgmt_write_q     <= 1'b1;
            mgmt_address_q   <= REG_START;
            mgmt_writedata_q <= 32'd1;
          end else if (!mgmt_waitrequest) begin
            mgmt_write_q <= 1'b0;
            timer_q      <= '0;
            state_q      <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          // The 16-cycle floor masks the stale lock still in the synchroniser.
          if (locked && (timer_q >= TMR_W'(16))) begin
            cur_mode_q <= tgt_q;
            lock_err_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            lock_err_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_BOOT;
      endcase

      if (req_evt && ((state_q != S_IDLE) || pend_vld_q)) begin
        if (mode_sync != cmp_mode) begin
          pend_q     <= mode_sync;
          pend_vld_q <= 1'b1;
        end else begin
          pend_vld_q <= 1'b0;
        end
      end
    end
  end

  assign tbl_addr       = tbl_addr_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_write     = mgmt_write_q;
  assign mgmt_writedata = mgmt_writedata_q;
  assign busy           = busy_q;
  assign cur_mode       = cur_mode_q;
  assign lock_err       = lock_err_q;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer: table-driven mode switches plus
// hand-written glitch, pending-request and mid-sequence reset cases.
module tb_pll_mode_sequencer;
  import pll_cfg_pkg::*;

  localparam int NM = 4, NE = 8, LT = 100, MW = 2, AW = 5;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] mode_sel = '0;
  logic          pll_locked = 1'b1;
  logic [AW-1:0] tbl_addr;
  logic [37:0]   tbl_data;
  logic [5:0]    mgmt_address;
  logic          mgmt_write;
  logic [31:0]   mgmt_writedata;
  logic          mgmt_waitrequest = 1'b0;
  logic          busy;
  logic [MW-1:0] cur_mode;
  logic          lock_err;

  pll_mode_sequencer #(.NUM_MODES(NM), .ENTRIES(NE), .LOCK_TIMEOUT(LT)) dut (
    .refclk(refclk), .rst(rst), .mode_sel(mode_sel), .pll_locked(pll_locked),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .cur_mode(cur_mode),
    .lock_err(lock_err)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [MW-1:0] mode;
    bit            ws;
    bit            lock;
    logic [MW-1:0] exp_cur;
    bit            exp_err;
  } scn_t;

  int   total = 0, bad = 0, cyc = 0;
  logic [37:0] rom [0:31];
  wr_t  exp_wr [NM][10];
  int   exp_n [NM];
  wr_t  log_q [$];
  bit   ws_en = 0, lock_en = 1;
  int   start_cyc = 0, err_cyc = 0;

  always @(posedge refclk) tbl_data <= rom[tbl_addr];
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (busy !== val && n < budget) begin
      @(negedge refclk);
      n++;
    end
    check(name, 64'(busy), 64'(val));
  endtask

  // Avalon slave model: optional 3-cycle stall per write, write log, lock model.
  initial begin
    int ws_cnt = 0, lk_cnt = 0;
    bit prev_stall = 0, prev_err = 0;
    logic [5:0] pa = '0;
    logic [31:0] pd = '0;
    forever begin
      @(negedge refclk);
      if (prev_stall)
        check("stall_hold", {25'd0, mgmt_write, mgmt_address, mgmt_writedata},
                            {25'd0, 1'b1, pa, pd});
      if (mgmt_write && ws_en && ws_cnt < 3) begin
        mgmt_waitrequest = 1'b1;
        ws_cnt++;
      end else begin
        mgmt_waitrequest = 1'b0;
        ws_cnt = 0;
      end
      prev_stall = mgmt_write && mgmt_waitrequest;
      pa = mgmt_address;
      pd = mgmt_writedata;
      if (mgmt_write && !mgmt_waitrequest) begin
        log_q.push_back('{mgmt_address, mgmt_writedata});
        if (mgmt_address == REG_START) begin
          start_cyc  = cyc;
          pll_locked = 1'b0;
          lk_cnt     = 20;
        end
      end else if (lk_cnt > 0) begin
        lk_cnt--;
        if (lk_cnt == 0 && lock_en) pll_locked = 1'b1;
      end
      if (lock_err && !prev_err) err_cyc = cyc;
      prev_err = lock_err;
    end
  end

  initial begin
    scn_t scn [7];

    for (int i = 0; i < 32; i++) rom[i] = {TBL_TERM, 32'h0};
    rom[0]  = {REG_M, 32'h0000_0101};
    rom[8]  = {REG_M, 32'h0000_0606};
    rom[9]  = {REG_N, 32'h0001_0000};
    rom[10] = {REG_C, 32'h0000_0303};
    rom[16] = {REG_M, 32'h0000_0808};
    rom[17] = {REG_N, 32'h0002_0000};
    rom[18] = {REG_C, 32'h0000_0404};
    rom[19] = {REG_C, 32'h0000_0405};
    rom[20] = {REG_C, 32'h0000_0406};
    rom[21] = {REG_C, 32'h0000_0407};
    rom[22] = {REG_K, 32'h0000_0055};
    rom[23] = {REG_K, 32'h0000_0056};

    exp_n[0] = 3;
    exp_wr[0][0] = '{6'd0, 32'd0};  exp_wr[0][1] = '{6'd4, 32'h101};  exp_wr[0][2] = '{6'd2, 32'd1};
    exp_n[1] = 5;
    exp_wr[1][0] = '{6'd0, 32'd0};  exp_wr[1][1] = '{6'd4, 32'h606};  exp_wr[1][2] = '{6'd3, 32'h10000};
    exp_wr[1][3] = '{6'd5, 32'h303}; exp_wr[1][4] = '{6'd2, 32'd1};
    exp_n[2] = 10;
    exp_wr[2][0] = '{6'd0, 32'd0};  exp_wr[2][1] = '{6'd4, 32'h808};  exp_wr[2][2] = '{6'd3, 32'h20000};
    exp_wr[2][3] = '{6'd5, 32'h404}; exp_wr[2][4] = '{6'd5, 32'h405}; exp_wr[2][5] = '{6'd5, 32'h406};
    exp_wr[2][6] = '{6'd5, 32'h407}; exp_wr[2][7] = '{6'd7, 32'h55};  exp_wr[2][8] = '{6'd7, 32'h56};
    exp_wr[2][9] = '{6'd2, 32'd1};
    exp_n[3] = 2;
    exp_wr[3][0] = '{6'd0, 32'd0};  exp_wr[3][1] = '{6'd2, 32'd1};

    //               mode  ws    lock  cur   err
    scn[0] = '{2'd1, 1'b0, 1'b1, 2'd1, 1'b0};
    scn[1] = '{2'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    scn[2] = '{2'd1, 1'b1, 1'b1, 2'd1, 1'b0};
    scn[3] = '{2'd2, 1'b0, 1'b0, 2'd1, 1'b1};
    scn[4] = '{2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
    scn[5] = '{2'd2, 1'b0, 1'b1, 2'd2, 1'b0};
    scn[6] = '{2'd0, 1'b0, 1'b1, 2'd0, 1'b0};

    // Reset state and boot
    repeat (3) @(negedge refclk);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_write", 64'(mgmt_write), 64'd0);
    check("rst_addr", {26'd0, tbl_addr, mgmt_address, mgmt_writedata[26:0]}, 64'd0);
    check("rst_cur_err", {61'd0, cur_mode, lock_err}, 64'd0);
    rst = 1'b0;
    wait_busy(1'b0, 4, "boot_busy_drop");
    check("boot_cur_err", {61'd0, cur_mode, lock_err}, 64'd0);
    check("boot_no_writes", 64'(log_q.size()), 64'd0);

    for (int s = 0; s < 7; s++) begin
      ws_en   = scn[s].ws;
      lock_en = scn[s].lock;
      log_q.delete();
      mode_sel = scn[s].mode;
      wait_busy(1'b1, 30, $sformatf("s%0d_busy_rise", s));
      wait_busy(1'b0, 400, $sformatf("s%0d_busy_fall", s));
      check($sformatf("s%0d_nwr", s), 64'(log_q.size()), 64'(exp_n[scn[s].mode]));
      for (int j = 0; j < exp_n[scn[s].mode] && j < log_q.size(); j++)
        check($sformatf("s%0d_wr%0d", s, j), 64'(log_q[j]), 64'(exp_wr[scn[s].mode][j]));
      check($sformatf("s%0d_cur", s), 64'(cur_mode), 64'(scn[s].exp_cur));
      check($sformatf("s%0d_err", s), 64'(lock_err), 64'(scn[s].exp_err));
      if (!scn[s].lock) check($sformatf("s%0d_tmo_cyc", s), 64'(err_cyc - start_cyc), 64'd101);
      repeat (3) @(negedge refclk);
    end

    // Two-cycle glitch on mode_sel must not start a sequence
    begin
      int busy_hi = 0;
      log_q.delete();
      mode_sel = 2'd1;
      repeat (2) @(negedge refclk);
      mode_sel = 2'd0;
      for (int i = 0; i < 20; i++) begin
        @(negedge refclk);
        if (busy) busy_hi++;
      end
      check("glitch_busy", 64'(busy_hi), 64'd0);
      check("glitch_nwr", 64'(log_q.size()), 64'd0);
    end

    // Request 1, then 2 while busy: mode 1 then mode 2, no repeat of mode 1
    begin
      int n = 0;
      log_q.delete();
      mode_sel = 2'd1;
      wait_busy(1'b1, 30, "pend_busy_rise");
      repeat (3) @(negedge refclk);
      mode_sel = 2'd2;
      while (cur_mode !== 2'd2 && n < 600) begin
        @(negedge refclk);
        n++;
      end
      wait_busy(1'b0, 20, "pend_busy_fall");
      check("pend_cur", 64'(cur_mode), 64'd2);
      check("pend_nwr", 64'(log_q.size()), 64'd15);
      for (int j = 0; j < 15 && j < log_q.size(); j++)
        check($sformatf("pend_wr%0d", j), 64'(log_q[j]),
              64'((j < 5) ? exp_wr[1][j] : exp_wr[2][j-5]));
    end

    // Reset during a table-entry write
    begin
      int n = 0;
      mode_sel = 2'd1;
      while (!(mgmt_write && mgmt_address == REG_M) && n < 60) begin
        @(negedge refclk);
        n++;
      end
      check("mid_reached_wr_ent", 64'(mgmt_write && mgmt_address == REG_M), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_write", 64'(mgmt_write), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd1);
      check("mid_rst_outs", {26'd0, tbl_addr, mgmt_address, mgmt_writedata[26:0]}, 64'd0);
      mode_sel = 2'd0;
      repeat (3) @(negedge refclk);
      rst = 1'b0;
      log_q.delete();
      wait_busy(1'b0, 10, "mid_boot_busy_drop");
      check("mid_boot_cur_err", {61'd0, cur_mode, lock_err}, 64'd0);
      repeat (20) @(negedge refclk);
      check("mid_no_writes", 64'(log_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
